// File: rtl/demux4_rr_sched_pkg.sv
// Shared types and constants for the round-robin 1-to-4 demux scheduler.
package demux4_rr_sched_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/demux4_rr_sched_demux1p4_struct.sv
// 1-to-4 demultiplexer: routes a single bit to the output selected by sel.
module demux1p4_struct
  import demux4_rr_sched_pkg::*;
(
  input  logic              data_in,
  input  ch_idx_t           sel,
  output logic [NUM_CH-1:0] out
);

  always_comb begin
    out      = '0;
    out[sel] = data_in;
  end

endmodule

// File: rtl/demux4_rr_sched.sv
// Round-robin scheduler feeding a 1-to-4 demux: one held word, bursts of up to
// BURST_LEN words per enabled channel, per-channel backpressure.
module demux4_rr_sched
  import demux4_rr_sched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] chan_en,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [1:0]        sel,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  state_t            state_q, state_d;
  ch_idx_t           ptr_q, ptr_d;
  ch_idx_t           tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  base, n;
  logic [DATA_W-1:0] data_q;
  logic              deliver, capture;

  // First enabled channel at or after start, wrapping; lowest offset wins.
  function automatic ch_idx_t next_enabled(input ch_idx_t start, input logic [NUM_CH-1:0] en);
    ch_idx_t c;
    next_enabled = start;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = start + ch_idx_t'(i);
      if (en[c]) next_enabled = c;
    end
  endfunction

  // Handshakes: a word moves on a side only in a cycle where valid && ready are
  // both high; valid never waits for ready. in_ready is combinational so a
  // delivery and a capture can share one cycle.
  assign deliver  = (state_q == ST_FULL) && out_ready[tgt_q];
  assign in_ready = rst_n && (|chan_en) && ((state_q == ST_EMPTY) || deliver);
  assign capture  = in_valid && in_ready;

  // Burst accounting, then the new target is searched from the updated pointer.
  always_comb begin
    base  = (tgt_q == ptr_q) ? cnt_q : '0;
    n     = base + CNT_W'(1);
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (deliver) begin
      if (n == CNT_W'(BURST_LEN)) begin
        ptr_d = tgt_q + 2'd1;
        cnt_d = '0;
      end else begin
        ptr_d = tgt_q;
        cnt_d = n;
      end
    end
    tgt_d = capture ? next_enabled(ptr_d, chan_en) : tgt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (capture)             state_d = ST_FULL;
      ST_FULL:  if (deliver && !capture) state_d = ST_EMPTY;
      default:                           state_d = ST_EMPTY;
    endcase
  end

  // busy is the FSM state itself and doubles as its observation point.
  always_comb begin
    busy = (state_q == ST_FULL);
    sel  = tgt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      tgt_q  <= '0;
      data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      if (capture) data_q <= in_data;
    end
  end

  assign out_data = data_q;

  demux1p4_struct u_demux (
    .data_in (busy),
    .sel     (sel),
    .out     (out_valid)
  );

endmodule
